phase_pair_gen: RTL

- Stimulus-side counterpart of the X/Y phase-delay measurer: generates two square waves, sig_x and sig_y, with the same programmable period and high time.
- The rising edge of sig_y lags the rising edge of sig_x by exactly DELAY clock cycles.
- Used as the on-chip source for phase measurement and for self-test loopback; a measurer clocked by the same clk must report fcont = DELAY.

---
 rtl/pg_pkg.sv | 27 ++
 rtl/pg_wave_cmp.sv | 28 ++
 rtl/phase_pair_gen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pg_pkg.sv
// Shared definitions for the phase pair generator: counter width, FSM encoding,
// configuration record and its legality check.
package pg_pkg;

    localparam int PG_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } pg_state_e;

    typedef struct packed {
        logic [PG_CNT_W-1:0] period;
        logic [PG_CNT_W-1:0] high;
        logic [PG_CNT_W-1:0] delay;
    } pg_cfg_t;

    // A waveform needs at least one low and one high cycle, and the lag must fit in a period.
    function automatic logic cfg_is_valid(input pg_cfg_t c);
        return (c.period >= PG_CNT_W'(2)) &&
               (c.high >= PG_CNT_W'(1)) &&
               (c.high < c.period) &&
               (c.delay < c.period);
    endfunction

endpackage

// File: rtl/pg_wave_cmp.sv
// Combinational phase/compare unit: next levels of sig_x and sig_y for a counter value.
module pg_wave_cmp
    import pg_pkg::*;
#(
    parameter int CNT_W = PG_CNT_W
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high,
    input  logic [CNT_W-1:0] delay,
    output logic             x_next,
    output logic             y_next
);

    logic [CNT_W-1:0] phase_s;

    // (cnt - delay) mod period without a divider; the intermediate may wrap but the result is < period
    always_comb begin
        if (cnt >= delay) begin
            phase_s = cnt - delay;
        end else begin
            phase_s = cnt + period - delay;
        end
        x_next = (cnt < high);
        y_next = (phase_s < high);
    end

endmodule

// File: rtl/phase_pair_gen.sv
// Two square waves with a common period/high time; sig_y rises exactly delay cycles after sig_x.
// Configuration is double-buffered and only ever takes effect on a period boundary.
module phase_pair_gen
    import pg_pkg::*;
#(
    parameter int CNT_W      = PG_CNT_W,
    parameter int RST_PERIOD = 100,
    parameter int RST_HIGH   = 50,
    parameter int RST_DELAY  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_delay,
    output logic             sig_x,
    output logic             sig_y,
    output logic             x_rise,
    output logic             running,
    output logic             cfg_err
);

    pg_state_e        state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    pg_cfg_t          act_r, pend_r, offer_s;
    logic             slot_empty_r, cfg_err_r;
    logic             sig_x_r, sig_y_r, x_rise_r, running_r;
    logic             first_r, first_nx_s;
    logic             x_cmp_s, y_cmp_s, y_gate_s;
    logic             x_nx_s, y_nx_s;
    logic             wrap_s, accept_s, apply_s;

    assign offer_s  = '{period: cfg_period, high: cfg_high, delay: cfg_delay};
    assign accept_s = cfg_valid && slot_empty_r;
    assign wrap_s   = (cnt_r == act_r.period - CNT_W'(1));

    pg_wave_cmp #(.CNT_W(CNT_W)) u_cmp (
        .cnt    (cnt_r),
        .period (act_r.period),
        .high   (act_r.high),
        .delay  (act_r.delay),
        .x_next (x_cmp_s),
        .y_next (y_cmp_s)
    );

    // Next state, counter and wave levels. In the first period after a start or a config
    // change sig_y may not rise before cnt reaches delay, so no spurious partial pulse appears.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        first_nx_s = first_r;
        x_nx_s     = 1'b0;
        y_nx_s     = 1'b0;
        apply_s    = 1'b0;
        if (first_r && (cnt_r < act_r.delay)) begin
            y_gate_s = y_cmp_s && sig_y_r;
        end else begin
            y_gate_s = y_cmp_s;
        end
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = '0;
                apply_s  = !slot_empty_r;
                if (en) begin
                    state_nx_s = ST_RUN;
                    first_nx_s = 1'b1;
                end else begin
                    first_nx_s = 1'b0;
                end
            end
            ST_RUN: begin
                x_nx_s = x_cmp_s;
                y_nx_s = y_gate_s;
                if (wrap_s) begin
                    cnt_nx_s   = '0;
                    apply_s    = en && !slot_empty_r;
                    first_nx_s = en && !slot_empty_r;
                    if (!en) begin
                        state_nx_s = y_gate_s ? ST_STOP : ST_IDLE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                // sig_y may only fall here; the FSM leaves as soon as it does
                y_nx_s   = y_cmp_s && sig_y_r;
                cnt_nx_s = wrap_s ? '0 : cnt_r + CNT_W'(1);
                if (!y_nx_s) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = '0;
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // FSM, counter and registered wave outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            first_r   <= 1'b0;
            sig_x_r   <= 1'b0;
            sig_y_r   <= 1'b0;
            x_rise_r  <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            cnt_r     <= cnt_nx_s;
            first_r   <= first_nx_s;
            sig_x_r   <= x_nx_s;
            sig_y_r   <= y_nx_s;
            x_rise_r  <= x_nx_s && !sig_x_r;
            running_r <= (state_nx_s != ST_IDLE);
        end
    end

    // Config handshake: accept into the pending slot, apply to active on a boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_r        <= '{period: CNT_W'(RST_PERIOD), high: CNT_W'(RST_HIGH),
                              delay: CNT_W'(RST_DELAY)};
            pend_r       <= '0;
            slot_empty_r <= 1'b1;
            cfg_err_r    <= 1'b0;
        end else if (accept_s) begin
            if (cfg_is_valid(offer_s)) begin
                pend_r       <= offer_s;
                slot_empty_r <= 1'b0;
                cfg_err_r    <= 1'b0;
            end else begin
                cfg_err_r    <= 1'b1;
            end
        end else if (apply_s) begin
            act_r        <= pend_r;
            slot_empty_r <= 1'b1;
        end
    end

    assign cfg_ready = slot_empty_r;
    assign cfg_err   = cfg_err_r;
    assign sig_x     = sig_x_r;
    assign sig_y     = sig_y_r;
    assign x_rise    = x_rise_r;
    assign running   = running_r;

endmodule
